// File: rtl/sram_like_pkg.sv
// ---------------------------------------------------------------------------
// sram_like_pkg : shared encodings for the sram-like bus arbiter
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package sram_like_pkg;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic [0:0] LOCK_IDLE = 1'b0;
  localparam logic [0:0] LOCK_HELD = 1'b1;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/id_fifo.sv
// ---------------------------------------------------------------------------
// id_fifo  : synchronous FIFO of issuing-channel IDs, wrap-around pointers
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module id_fifo
  import sram_like_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = clog2_min1(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [PTR_W-1:0] c_last  = PTR_W'(DEPTH-1);
  localparam logic [PTR_W-1:0] c_p_one = PTR_W'(1);
  localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] c_c_one = CNT_W'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty    = (r_count == '0);
  assign full     = (r_count == c_depth);
  assign count    = r_count;
  assign pop_data = r_mem[r_rd_ptr];

  // A pop in the same cycle frees the slot, so push is legal even when full.
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= (r_wr_ptr == c_last) ? '0 : r_wr_ptr + c_p_one;
      end
      if (w_do_pop) begin
        r_rd_ptr <= (r_rd_ptr == c_last) ? '0 : r_rd_ptr + c_p_one;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + c_c_one;
        2'b01:   r_count <= r_count - c_c_one;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/sram_like_arbiter.sv
// ---------------------------------------------------------------------------
// sram_like_arbiter : N-channel sram-like bus arbiter, fixed or round-robin,
//                     bounded outstanding with in-order response routing
// Revision          : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sram_like_arbiter
  import sram_like_pkg::*;
#(
  parameter int NUM_CH          = 2,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int RR_MODE         = 0
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_CH-1:0]                    m_req,
  input  logic [NUM_CH-1:0]                    m_wr,
  input  logic [NUM_CH*(DATA_W/8)-1:0]         m_wstrb,
  input  logic [NUM_CH*2-1:0]                  m_size,
  input  logic [NUM_CH*ADDR_W-1:0]             m_addr,
  input  logic [NUM_CH*DATA_W-1:0]             m_wdata,
  output logic [NUM_CH-1:0]                    m_addr_ok,
  output logic [NUM_CH-1:0]                    m_data_ok,
  output logic [DATA_W-1:0]                    m_rdata,
  output logic                                 s_req,
  output logic                                 s_wr,
  output logic [DATA_W/8-1:0]                  s_wstrb,
  output logic [1:0]                           s_size,
  output logic [ADDR_W-1:0]                    s_addr,
  output logic [DATA_W-1:0]                    s_wdata,
  input  logic                                 s_addr_ok,
  input  logic                                 s_data_ok,
  input  logic [DATA_W-1:0]                    s_rdata,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
  output logic                                 err_spurious
);

  localparam int CH_W   = clog2_min1(NUM_CH);
  localparam int STRB_W = DATA_W / 8;

  logic [0:0]      r_state;
  logic [0:0]      w_state_next;
  logic [CH_W-1:0] r_lock_ch;
  logic [CH_W-1:0] r_rr_ptr;
  logic            r_err_spurious;
  logic            w_locked;
  logic            w_sel_valid;
  logic [CH_W-1:0] w_sel_ch;
  logic            w_win_valid;
  logic [CH_W-1:0] w_winner;
  logic [CH_W-1:0] w_rr_next;
  logic            w_accept;
  logic            w_resp;
  logic [CH_W-1:0] w_fifo_head;
  logic            w_fifo_full;
  logic            w_fifo_empty;

  // Requester selection when no request is locked onto the slave.
  always_comb begin : p_select
    int v_idx;
    v_idx       = 0;
    w_sel_valid = 1'b0;
    w_sel_ch    = '0;
    if (RR_MODE == ARB_RR) begin
      for (int k = 0; k < NUM_CH; k++) begin
        v_idx = (int'(r_rr_ptr) + k) % NUM_CH;
        if (!w_sel_valid && m_req[CH_W'(v_idx)]) begin
          w_sel_valid = 1'b1;
          w_sel_ch    = CH_W'(v_idx);
        end
      end
    end else begin
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (m_req[i]) begin
          w_sel_valid = 1'b1;
          w_sel_ch    = CH_W'(i);
        end
      end
    end
  end

  assign w_winner    = reset ? '0 : (w_locked ? r_lock_ch : w_sel_ch);
  assign w_win_valid = ~reset & (w_locked | w_sel_valid);
  assign w_rr_next   = CH_W'((int'(w_winner) + 1) % NUM_CH);

  assign s_req    = w_win_valid & ~w_fifo_full;
  assign w_accept = s_req & s_addr_ok;
  assign w_resp   = s_data_ok & ~w_fifo_empty & ~reset;
  assign m_rdata  = s_rdata;

  always_comb begin
    s_wr    = m_wr[0];
    s_wstrb = m_wstrb[STRB_W-1:0];
    s_size  = m_size[1:0];
    s_addr  = m_addr[ADDR_W-1:0];
    s_wdata = m_wdata[DATA_W-1:0];
    for (int i = 1; i < NUM_CH; i++) begin
      if (w_winner == CH_W'(i)) begin
        s_wr    = m_wr[i];
        s_wstrb = m_wstrb[i*STRB_W +: STRB_W];
        s_size  = m_size[i*2 +: 2];
        s_addr  = m_addr[i*ADDR_W +: ADDR_W];
        s_wdata = m_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    m_addr_ok = '0;
    m_data_ok = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_addr_ok[i] = w_accept && (w_winner == CH_W'(i));
      m_data_ok[i] = w_resp && (w_fifo_head == CH_W'(i));
    end
  end

  // Lock FSM: keeps a stalled request's fields stable until the slave takes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= LOCK_IDLE;
      r_lock_ch <= '0;
    end else begin
      r_state <= w_state_next;
      if (s_req && !s_addr_ok) begin
        r_lock_ch <= w_winner;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      LOCK_IDLE: if (s_req && !s_addr_ok) w_state_next = LOCK_HELD;
      LOCK_HELD: if (w_accept)            w_state_next = LOCK_IDLE;
      default:                            w_state_next = LOCK_IDLE;
    endcase
  end

  always_comb begin
    w_locked = (r_state == LOCK_HELD);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr       <= '0;
      r_err_spurious <= 1'b0;
    end else begin
      if (w_accept && (RR_MODE == ARB_RR)) begin
        r_rr_ptr <= w_rr_next;
      end
      r_err_spurious <= r_err_spurious | (s_data_ok & w_fifo_empty);
    end
  end

  assign err_spurious = r_err_spurious;

  id_fifo #(
    .WIDTH (CH_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_accept),
    .push_data (w_winner),
    .pop       (w_resp),
    .pop_data  (w_fifo_head),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty),
    .count     (outstanding)
  );

endmodule

`default_nettype wire

// File: doc/sram_like_arbiter.md
# sram_like_arbiter

Parametrised N-channel arbiter for the core's sram-like bus (req/addr_ok/data_ok). Sits between the CPU core's master ports (instruction fetch, data access, and later any refill/TLB walker) and one shared sram-like slave, typically the AXI bridge. It generalises the current fixed two-port wiring with:

- a configurable channel count;
- fixed-priority or round-robin arbitration;
- a bounded number of outstanding transactions, with in-order routing of data_ok/rdata back to the issuing channel.

## Interface
- NUM_CH, 2: number of master channels (≥1); channel 0 is highest priority in fixed mode.
- ADDR_W, 32: address width.
- DATA_W, 32: data width (multiple of 8).
- MAX_OUTSTANDING, 4: accepted-but-unanswered transactions allowed (≥1).
- RR_MODE, 0: 0 = fixed priority; 1 = round-robin.

Ports. Clock `clk`, reset `reset`: one clock; reset is synchronous and active-high. Master buses are flat-packed, with channel i in slice i.
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- m_req  in  NUM_CH  per-channel request
- m_wr  in  NUM_CH  per-channel write flag
- m_wstrb  in  NUM_CH*DATA_W/8  byte strobes
- m_size  in  NUM_CH*2  access size
- m_addr  in  NUM_CH*ADDR_W  address
- m_wdata  in  NUM_CH*DATA_W  write data
- m_addr_ok  out  NUM_CH  request accepted, at most one bit high
- m_data_ok  out  NUM_CH  response for the channel, at most one bit high
- m_rdata  out  DATA_W  read data, broadcast to all channels
- s_req / s_wr / s_wstrb / s_size / s_addr / s_wdata  out  1/1/DATA_W/8/2/ADDR_W/DATA_W  to slave
- s_addr_ok  in  1  slave accepted request
- s_data_ok  in  1  slave response
- s_rdata  in  DATA_W  slave read data
- outstanding  out  $clog2(MAX_OUTSTANDING+1)  current in-flight count
- err_spurious  out  1  sticky: s_data_ok received with nothing outstanding

## Operation
- Grant:
  - When unlocked, the winner is the requesting channel chosen by the mode.
  - Fixed mode: lowest index wins.
  - RR mode: first requester at or after rr_ptr, wrapping modulo NUM_CH.
- Issue:
  - s_req = winner exists AND outstanding < MAX_OUTSTANDING.
  - All s_* fields are muxed from the winner.
- Lock:
  - If s_req=1 and s_addr_ok=0, register lock_valid=1 and lock_ch=winner.
  - While locked, the winner is lock_ch regardless of other requests, so s_addr/s_wdata stay stable.
  - The lock clears on the s_addr_ok handshake.
- Handshake:
  - m_addr_ok[winner] = s_req & s_addr_ok.
  - On handshake: push winner index into the ID FIFO and increment outstanding.
  - In RR mode, also set rr_ptr = (winner+1) mod NUM_CH.
- Response:
  - m_data_ok[fifo_head] = s_data_ok when FIFO non-empty.
  - On s_data_ok: pop the FIFO and decrement outstanding.
  - m_rdata = s_rdata, unconditional.
- Spurious response: s_data_ok with empty FIFO produces no m_data_ok, no pop, and sets err_spurious (held until reset).
- Simultaneous handshake and response in one cycle: push and pop both occur, and outstanding is unchanged.
- Full: at outstanding = MAX_OUTSTANDING, s_req is held low even if locked; the lock is kept. Issue resumes in the cycle after a pop.
- Reset:
  - Clears FIFO, outstanding, lock and rr_ptr (to 0), and err_spurious.
  - In-flight transactions are dropped; responses arriving afterwards count as spurious.

## Timing
- Request path is combinational: m_req → s_req, and s_addr_ok → m_addr_ok, with zero added latency.
- Response path is combinational: s_data_ok → m_data_ok, with zero added latency.
- The FIFO, count, lock and rr_ptr update on the clk edge after the handshake.
- A new winner is visible in the cycle after an accept.
- Reset values: s_req=0, m_addr_ok=0, m_data_ok=0, outstanding=0, err_spurious=0. The s_* data fields follow channel 0 inputs.
- The FIFO head must be valid in the same cycle as the push into an empty FIFO plus one. A response in the accept cycle itself is illegal slave behaviour and is not supported.

## Structure
- Shared package `sram_like_pkg`: RR_MODE encodings (ARB_FIXED=0, ARB_RR=1) and the SIZE encodings (byte/half/word).
- Sub-module `id_fifo`:
  - synchronous FIFO of width $clog2(NUM_CH) (min 1) and depth MAX_OUTSTANDING;
  - push/pop/full/empty/count;
  - wrap-around read/write pointers;
  - simultaneous push+pop allowed when full or empty.
- The arbiter logic (priority/RR select, lock) lives in the top module.

## Test plan
- Single channel: ch1 read 0x1c000000, slave addr_ok same cycle, data_ok 3 cycles later with 0xdeadbeef → m_addr_ok=2'b10, then m_data_ok=2'b10 and m_rdata=0xdeadbeef; outstanding 0→1→0.
- Fixed priority, NUM_CH=2: both req every cycle, addr_ok always 1 → ch0 granted every cycle. With RR_MODE=1, grants alternate 0,1,0,1.
- Lock: ch1 req with s_addr_ok low for 4 cycles, ch0 raises req at cycle 2 → s_addr holds ch1's address all 4 cycles; ch0 is granted only after ch1's accept.
- Full: MAX_OUTSTANDING=2, three accepts attempted without data_ok → third s_req=0 until one data_ok; then it issues next cycle. Responses return to channels in issue order.
- Simultaneous accept and response at outstanding=2 (full) → s_req=0 that cycle. At outstanding=1, simultaneous push+pop leaves outstanding=1.
- Spurious/reset: reset with 2 in flight, then s_data_ok → no m_data_ok, err_spurious=1 until next reset.
